// File: rtl/mips_bus_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_bus_lsu                                                 |
// | Description : Load/store unit bridging the multicycle MIPS core to an      |
// |               Avalon-MM master port. Lane-aligns address, byteenable and   |
// |               write data; extends load data; traps misaligned accesses    |
// |               and optionally times out stalled bus cycles.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mips_bus_lsu #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic                resp_error,
  output logic                busy,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [2:0]        r_op;
  logic [OFF_W-1:0]  r_off;
  logic [ADDR_W-1:0] r_address;
  logic [LANES-1:0]  r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [31:0]       r_stall_cnt;
  logic              r_error;
  logic [31:0]       r_rdata;

  logic              w_accept;
  logic [OFF_W-1:0]  w_off;
  logic [2:0]        w_size;
  logic              w_misaligned;
  logic [LANES-1:0]  w_be_base;
  logic [LANES-1:0]  w_be;
  logic [DATA_W-1:0] w_wdata_rep;
  logic              w_is_store;
  logic [DATA_W-1:0] w_shifted;
  logic [31:0]       w_lane;
  logic [31:0]       w_load;
  logic              w_timeout;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_off      = req_addr[OFF_W-1:0];
  assign w_is_store = (r_op >= 3'd5);

  // Decode access size, alignment, lane mask and replicated store data of the incoming request
  always_comb begin
    w_size      = 3'd4;
    w_be_base   = LANES'(4'hF);
    w_wdata_rep = {(LANES/4){req_wdata}};
    case (req_op)
      3'd0, 3'd1, 3'd5: begin
        w_size      = 3'd1;
        w_be_base   = LANES'(1'b1);
        w_wdata_rep = {LANES{req_wdata[7:0]}};
      end
      3'd2, 3'd3, 3'd6: begin
        w_size      = 3'd2;
        w_be_base   = LANES'(2'b11);
        w_wdata_rep = {(LANES/2){req_wdata[15:0]}};
      end
      default: ;
    endcase
    w_misaligned = ((w_size == 3'd2) && w_off[0]) ||
                   ((w_size == 3'd4) && (w_off[1:0] != 2'b00));
    w_be = w_be_base << w_off;
  end

  // Shift the addressed lanes down and sign/zero-extend according to the latched op
  always_comb begin
    w_shifted = readdata >> {r_off, 3'b000};
    w_lane    = w_shifted[31:0];
    case (r_op)
      3'd0:    w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      3'd1:    w_load = {24'd0, w_lane[7:0]};
      3'd2:    w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      3'd3:    w_load = {16'd0, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

  // Next-state logic; the timeout fires on the stall cycle that brings the count to the limit
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_misaligned ? S_RESP : S_BUS;
        end
      end
      S_BUS: begin
        if (!waitrequest) begin
          w_next = S_RESP;
        end else if ((TIMEOUT_CYCLES != 0) &&
                     (r_stall_cnt == 32'(TIMEOUT_CYCLES - 1))) begin
          w_next    = S_RESP;
          w_timeout = 1'b1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus request latching, stall counting and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= 3'd0;
      r_off       <= '0;
      r_address   <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_stall_cnt <= 32'd0;
      r_error     <= 1'b0;
      r_rdata     <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op        <= req_op;
            r_off       <= w_off;
            r_address   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_be        <= w_be;
            r_wdata     <= w_wdata_rep;
            r_stall_cnt <= 32'd0;
            r_error     <= w_misaligned;
            r_rdata     <= 32'd0;
          end
        end
        S_BUS: begin
          if (!waitrequest) begin
            if (!w_is_store) begin
              r_rdata <= w_load;
            end
          end else begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_timeout) begin
              r_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign read       = (r_state == S_BUS) && !w_is_store;
  assign write      = (r_state == S_BUS) && w_is_store;
  assign resp_valid = (r_state == S_RESP);
  assign resp_error = (r_state == S_RESP) && r_error;
  assign resp_rdata = r_rdata;
  assign address    = r_address;
  assign byteenable = r_be;
  assign writedata  = r_wdata;

endmodule
`default_nettype wire
